// File: rtl/scan_chain_controller.sv
// Scan-test initiator for a serial SDFF chain: shift in, capture, shift out, compare.
// Optional error accumulator enabled by defining STC_ERRCNT_EN.
module scan_chain_controller #(
    parameter int unsigned CHAIN_LEN = 4
`ifdef STC_ERRCNT_EN
    ,
    parameter int unsigned ERRCNT_W  = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic                 so,
`ifdef STC_ERRCNT_EN
    input  logic                 clr_err,
    output logic [ERRCNT_W-1:0]  err_cnt,
`endif
    output logic                 se,
    output logic                 si,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response
);

    localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CHAIN_LEN-1:0]  pattern_q;
    logic [CHAIN_LEN-1:0]  expect_q;
    logic [CHAIN_LEN-1:0]  resp;
    logic [CHAIN_LEN-1:0]  resp_next;
    logic [CNT_W-1:0]      si_idx;
    logic                  si_next;
    logic                  last_cnt;

    // Next serial bit (MSB first) and the response with the current SO appended
    always_comb begin
        resp_next = {resp[CHAIN_LEN-2:0], so};
        si_idx    = CNT_W'(CHAIN_LEN - 2) - cnt;
        si_next   = pattern_q[si_idx];
        last_cnt  = (cnt == CNT_LAST);
    end

    // Sequencer; all chain-facing outputs are flops loaded with the value for the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pattern_q <= '0;
            expect_q  <= '0;
            resp      <= '0;
            se        <= 1'b0;
            si        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            response  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    se    <= 1'b0;
                    si    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        pattern_q <= pattern;
                        expect_q  <= expected;
                        cnt       <= '0;
                        state     <= S_SHIFT_IN;
                        se        <= 1'b1;
                        si        <= pattern[CHAIN_LEN-1];
                        busy      <= 1'b1;
                    end
                end
                S_SHIFT_IN: begin
                    if (last_cnt) begin
                        state <= S_CAPTURE;
                        cnt   <= '0;
                        se    <= 1'b0;
                        si    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        si  <= si_next;
                    end
                end
                S_CAPTURE: begin
                    state <= S_SHIFT_OUT;
                    cnt   <= '0;
                    se    <= 1'b1;
                    si    <= 1'b0;
                end
                S_SHIFT_OUT: begin
                    resp <= resp_next;
                    if (last_cnt) begin
                        state    <= S_DONE;
                        se       <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= (resp_next == expect_q);
                        response <= resp_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    se    <= 1'b0;
                    si    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STC_ERRCNT_EN
    localparam int unsigned POP_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned SUM_W = ((ERRCNT_W > POP_W) ? ERRCNT_W : POP_W) + 1;
    localparam logic [ERRCNT_W-1:0] ERR_MAX = '1;

    logic [CHAIN_LEN-1:0] mism;
    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     err_sum;
    logic [ERRCNT_W-1:0]  err_cnt_next;

    // Saturating accumulation of mismatching bits for the pattern about to complete
    always_comb begin
        mism = resp_next ^ expect_q;
        pop  = '0;
        for (int i = 0; i < int'(CHAIN_LEN); i++) begin
            pop = pop + POP_W'(mism[i]);
        end
        err_sum      = SUM_W'(err_cnt) + SUM_W'(pop);
        err_cnt_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : ERRCNT_W'(err_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (state == S_SHIFT_OUT && last_cnt) begin
            err_cnt <= err_cnt_next;
        end
    end
`endif

endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
- Scan-test initiator that drives a serial SDFF scan chain, such as the 4-stage chain built from SDFF cells.
- For each test pattern it shifts the stimulus in through the chain's SI with SE=1, holds SE=0 for one capture cycle, then shifts the response out of the last stage's SO and compares it with the expected vector.
- Sits between the test bench or test-access logic and the chain's SI/SE/SO pins; shares CLK with the chain.

Parameters:
- CHAIN_LEN, 4, number of SDFF stages in the driven chain (>=2).
- ERRCNT_W, 8, width of the error counter (used only with STC_ERRCNT_EN).

Ports:
- CLK  input  1  rising-edge clock, shared with the scan chain.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request to run one pattern; sampled only in IDLE or DONE.
- PATTERN  input  CHAIN_LEN  stimulus; bit i is destined for stage i+1 (stage 1 is nearest SI).
- EXPECT  input  CHAIN_LEN  expected captured value; bit i is stage i+1.
- SO  input  1  serial output of the last chain stage.
- SE  output  1  scan enable to all chain stages.
- SI  output  1  serial input to chain stage 1.
- BUSY  output  1  high from SHIFT_IN through SHIFT_OUT.
- DONE  output  1  one-cycle pulse when RESPONSE and PASS are valid.
- PASS  output  1  RESPONSE==EXPECT for the last completed pattern.
- RESPONSE  output  CHAIN_LEN  captured chain contents, same bit mapping as PATTERN.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, counter=0, SE=0, SI=0, BUSY=0, DONE=0, PASS=0, RESPONSE=0.
  - Chain contents are don't-care.
  - Reset mid-operation aborts the pattern with no DONE.
- SE, SI, BUSY and DONE are decoded from the registered state and counter only; there is no combinational path from any input.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE:
  - SE=0, SI=0.
  - START=1 at an edge: latch PATTERN and EXPECT, cnt<=0, go to SHIFT_IN.
- SHIFT_IN (CHAIN_LEN cycles, cnt 0..CHAIN_LEN-1):
  - SE=1, SI=pattern_q[CHAIN_LEN-1-cnt], so the MSB is shifted first.
  - At cnt=CHAIN_LEN-1, go to CAPTURE.
- CAPTURE (1 cycle):
  - SE=0, SI=0; the chain loads DI on this edge.
  - cnt<=0, go to SHIFT_OUT.
- SHIFT_OUT (CHAIN_LEN cycles):
  - SE=1, SI=0.
  - Each edge: resp<={resp[CHAIN_LEN-2:0],SO}. The first sample is stage CHAIN_LEN, landing in RESPONSE MSB.
  - At cnt=CHAIN_LEN-1, go to DONE.
- DONE (1 cycle):
  - DONE=1, SE=0.
  - PASS=(resp==expect_q), registered on entry to DONE.
  - RESPONSE and PASS hold until the next DONE or reset.
  - START=1 in DONE re-latches the inputs and goes directly to SHIFT_IN (back-to-back operation); otherwise go to IDLE.
- Latency: with START sampled at edge 0, DONE is high in the cycle after edge 2*CHAIN_LEN+1.
- START in SHIFT_IN, CAPTURE or SHIFT_OUT is ignored; there is no queueing.
- Changes to PATTERN and EXPECT after acceptance have no effect.

Optional Feature:
- Macro: STC_ERRCNT_EN.
- Defined:
  - Adds input CLR_ERR (1 bit) and output ERR_CNT (ERRCNT_W bits).
  - On entry to DONE, ERR_CNT += popcount(resp ^ expect_q), saturating at all-ones.
  - CLR_ERR=1 clears ERR_CNT synchronously; CLR_ERR wins over a simultaneous add.
  - ERR_CNT resets to 0.
- Undefined: ERR_CNT and CLR_ERR ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Capture check (CHAIN_LEN=4, chain DI={DI4..DI1}=4'b1010), PATTERN=4'b0110, EXPECT=4'b1010 -> SE=1,1,1,1,0,1,1,1,1 then 0; SI=0,1,1,0 during SHIFT_IN; DONE after edge 9; RESPONSE=1010, PASS=1.
- Loopback (chain DIn tied to that stage's own Q), PATTERN=4'b1101, EXPECT=4'b1101 -> RESPONSE=1101, PASS=1; proves shift order and bit mapping.
- Mismatch: DI=4'b1010, EXPECT=4'b0011 -> PASS=0, RESPONSE=1010; with STC_ERRCNT_EN, ERR_CNT 0->2, then CLR_ERR -> 0.
- START pulsed in SHIFT_IN cycle 2 and in CAPTURE -> ignored, exactly one DONE; START held high through DONE -> second pattern begins the next cycle with SE=1, no IDLE cycle.
- RST_N low during SHIFT_OUT cycle 1 -> SE, SI, BUSY, DONE, PASS and RESPONSE go to 0 immediately; no DONE; a fresh START after release completes normally.
- With STC_ERRCNT_EN and ERRCNT_W=3: repeat a 4-bit-mismatch pattern twice -> ERR_CNT=4, then 7 (saturated), and stays 7 on a third pattern.
